// File: rtl/spi_slave_regfile.sv
// spi_slave_regfile: oversampled SPI responder (mode 0) with a register file; optional SPI_SLAVE_FRAME_ERR_EN
module spi_slave_regfile #(
  parameter int DATA_BIT    = 4,
  parameter int ADDR_BIT    = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                CSN,
  input  logic                SCLK,
  input  logic                MOSI,
  output logic                MISO,
  output logic                MISO_OE,
  output logic                WR_STROBE,
  output logic [ADDR_BIT-1:0] WR_ADDR_O,
  output logic [DATA_BIT-1:0] WR_DATA_O,
  input  logic [ADDR_BIT-1:0] DBG_ADDR,
  output logic [DATA_BIT-1:0] DBG_DATA,
  output logic                FRAME_ERR
);
  localparam int MW = ADDR_BIT > DATA_BIT ? ADDR_BIT : DATA_BIT;
  localparam int CW = $clog2(MW + 1);
  typedef enum logic [2:0] {IDLE, CMD, ADDR, WDATA, RDATA, DONE, IGNORE} state_t;
  state_t r_state, w_next;
  logic [SYNC_STAGES-1:0] r_csn_sync, r_sclk_sync, r_mosi_sync;
  logic r_sclk_prev;
  logic [CW-1:0] r_cnt;
  logic [1:0] r_cmd;
  logic [ADDR_BIT-1:0] r_addr, w_addr_nxt;
  logic [DATA_BIT-1:0] r_wdata, r_rd, w_wdata_nxt;
  logic [DATA_BIT-1:0] r_mem [2**ADDR_BIT];
  logic w_csn, w_sclk, w_mosi, w_rise, w_fall, w_abort, w_addr_done, w_load, w_commit;
  assign w_csn       = r_csn_sync[SYNC_STAGES-1];
  assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
  assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
  // Edges are only honoured while the frame is live; CSN high takes priority as an abort.
  assign w_rise      = w_sclk & ~r_sclk_prev & ~w_csn;
  assign w_fall      = ~w_sclk & r_sclk_prev & ~w_csn;
  assign w_abort     = w_csn && r_state != IDLE;
  assign w_addr_nxt  = ADDR_BIT'({r_addr, w_mosi});
  assign w_wdata_nxt = DATA_BIT'({r_wdata, w_mosi});
  assign w_addr_done = r_state == ADDR && w_rise && r_cnt == CW'(ADDR_BIT - 1);
  assign w_load      = w_addr_done && r_cmd == 2'b01;
  assign w_commit    = r_state == WDATA && w_rise && r_cnt == CW'(DATA_BIT - 1);
  assign MISO_OE     = r_state == RDATA;
  assign MISO        = MISO_OE & r_rd[DATA_BIT-1];
  assign DBG_DATA    = r_mem[DBG_ADDR];
  // Input synchronizers, SCLK history and the state register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_csn_sync  <= '1;
      r_sclk_sync <= '0;
      r_mosi_sync <= '0;
      r_sclk_prev <= 1'b0;
      r_state     <= IDLE;
    end else begin
      r_csn_sync  <= {r_csn_sync[SYNC_STAGES-2:0], CSN};
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], SCLK};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], MOSI};
      r_sclk_prev <= w_sclk;
      r_state     <= w_next;
    end
  end
  // Next-state decode, one transition per detected event.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_csn ? IDLE : CMD;
      CMD:     w_next = (w_rise && r_cnt == CW'(1)) ? ADDR : CMD;
      ADDR:    w_next = !w_addr_done ? ADDR : r_cmd == 2'b10 ? WDATA : r_cmd == 2'b01 ? RDATA : IGNORE;
      WDATA:   w_next = w_commit ? DONE : WDATA;
      RDATA:   w_next = (w_fall && r_cnt == CW'(DATA_BIT)) ? DONE : RDATA;
      default: w_next = r_state;
    endcase
    if (w_abort) w_next = IDLE;
  end
  // Datapath: bit counter, shift registers, register file and write port.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_cnt     <= '0;
      r_cmd     <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rd      <= '0;
      WR_STROBE <= 1'b0;
      WR_ADDR_O <= '0;
      WR_DATA_O <= '0;
      for (int i = 0; i < 2**ADDR_BIT; i++) r_mem[i] <= '0;
    end else begin
      WR_STROBE <= 1'b0;
      r_cnt <= (w_next != r_state) ? '0 :
               (w_rise && r_state inside {CMD, ADDR, WDATA, RDATA}) ? r_cnt + 1'b1 : r_cnt;
      if (w_abort) begin
        r_cmd   <= '0;
        r_addr  <= '0;
        r_wdata <= '0;
        r_rd    <= '0;
      end else begin
        if (r_state == CMD && w_rise) r_cmd <= {r_cmd[0], w_mosi};
        if (r_state == ADDR && w_rise) r_addr <= w_addr_nxt;
        if (r_state == WDATA && w_rise) r_wdata <= w_wdata_nxt;
        if (w_load) r_rd <= r_mem[w_addr_nxt];
        // The fall trailing the last address bit (counter still 0) must not shift, so the MSB meets the first data rise.
        if (r_state == RDATA && w_fall && r_cnt != '0) r_rd <= r_rd << 1;
        if (w_commit) begin
          r_mem[r_addr] <= w_wdata_nxt;
          WR_STROBE     <= 1'b1;
          WR_ADDR_O     <= r_addr;
          WR_DATA_O     <= w_wdata_nxt;
        end
      end
    end
  end
`ifdef SPI_SLAVE_FRAME_ERR_EN
  // Sticky error on a mid-frame abort or an undefined command.
  always_ff @(posedge CLK) begin
    if (RST) FRAME_ERR <= 1'b0;
    else if ((w_abort && r_state != DONE) || (w_addr_done && (r_cmd == 2'b00 || r_cmd == 2'b11))) FRAME_ERR <= 1'b1;
  end
`else
  assign FRAME_ERR = 1'b0;
`endif
endmodule
